// File: rtl/invaders_pkg.sv
// Shared constants and state encoding for the invader formation logic.
// Grid geometry lives here so the renderer and the formation agree on it.
package invaders_pkg;

  localparam int unsigned COLS        = 8;
  localparam int unsigned ROWS        = 3;
  localparam int unsigned DX          = 80;
  localparam int unsigned DY          = 50;
  localparam int unsigned ENEMY_W     = 32;
  localparam int unsigned ENEMY_H     = 24;

  localparam int unsigned NUM_ENEMIES = COLS * ROWS;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned CNT_W       = $clog2(NUM_ENEMIES + 1);
  localparam int unsigned COL_W       = $clog2(COLS);
  localparam int unsigned ROW_W       = $clog2(ROWS);
  localparam int unsigned CRD_W       = 11;

  typedef enum logic [1:0] {
    StMarchR = 2'd0,
    StMarchL = 2'd1,
    StHalt   = 2'd2
  } state_e;

endpackage

// File: rtl/formation_hit_detect.sv
// Combinational shot-vs-grid collision with lowest-index priority, plus the
// live-column/row edge finder used by the march logic.
module formation_hit_detect
  import invaders_pkg::*;
(
  input  logic [CRD_W-1:0]       base_x_i,
  input  logic [CRD_W-1:0]       base_y_i,
  input  logic [CRD_W-1:0]       shot_x_i,
  input  logic [CRD_W-1:0]       shot_y_i,
  input  logic [NUM_ENEMIES-1:0] alive_i,
  output logic                   hit_any_o,
  output logic [IDX_W-1:0]       hit_idx_o,
  output logic [COL_W-1:0]       lc_o,
  output logic [COL_W-1:0]       rc_o,
  output logic [ROW_W-1:0]       lr_o
);

  logic [NUM_ENEMIES-1:0] in_box;
  logic [COLS-1:0]        col_alive;
  logic [ROWS-1:0]        row_alive;

  for (genvar k = 0; k < NUM_ENEMIES; k++) begin : g_box
    localparam int unsigned Col = k % COLS;
    localparam int unsigned Row = k / COLS;
    logic [CRD_W-1:0] x_lo;
    logic [CRD_W-1:0] y_lo;
    assign x_lo = base_x_i + CRD_W'(Col * DX);
    assign y_lo = base_y_i + CRD_W'(Row * DY);
    assign in_box[k] = alive_i[k] &&
                       (shot_x_i >= x_lo) && (shot_x_i < x_lo + CRD_W'(ENEMY_W)) &&
                       (shot_y_i >= y_lo) && (shot_y_i < y_lo + CRD_W'(ENEMY_H));
  end

  assign hit_any_o = |in_box;

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    hit_idx_o = '0;
    for (int k = NUM_ENEMIES - 1; k >= 0; k--) begin
      if (in_box[k]) hit_idx_o = IDX_W'(k);
    end
  end

  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_alive[c] = col_alive[c] | alive_i[r*COLS+c];
        row_alive[r] = row_alive[r] | alive_i[r*COLS+c];
      end
    end
  end

  always_comb begin
    lc_o = '0;
    rc_o = '0;
    lr_o = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_alive[c]) lc_o = COL_W'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_alive[c]) rc_o = COL_W'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_alive[r]) lr_o = ROW_W'(r);
    end
  end

endmodule

// File: rtl/enemy_formation.sv
// Invader formation controller: marches the grid base, tracks the alive mask
// and resolves player-shot hits. All outputs are registered.
module enemy_formation
  import invaders_pkg::*;
#(
  parameter int unsigned X0       = 180,
  parameter int unsigned Y0       = 40,
  parameter int unsigned STEP_X   = 4,
  parameter int unsigned STEP_Y   = 10,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 780,
  parameter int unsigned Y_LIMIT  = 400,
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   restart,
  input  logic                   shot_valid,
  input  logic [CRD_W-1:0]       shot_x,
  input  logic [CRD_W-1:0]       shot_y,
  output logic [9:0]             base_x,
  output logic [9:0]             base_y,
  output logic [NUM_ENEMIES-1:0] alive,
  output logic [CNT_W-1:0]       alive_count,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_id,
  output logic                   reached_bottom,
  output logic                   all_dead
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e                 state_q, state_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [CRD_W-1:0]       base_x_q, base_x_d;
  logic [CRD_W-1:0]       base_y_q, base_y_d;
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       hit_id_q, hit_id_d;
  logic                   reached_q, reached_d;
  logic                   all_dead_q, all_dead_d;
  logic                   armed_q, armed_d;

  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;
  logic [COL_W-1:0]       lc, rc;
  logic [ROW_W-1:0]       lr;
  logic [CRD_W-1:0]       edge_l, edge_r, descent_y, bottom;
  logic                   tick, shot_hit, descend;

  formation_hit_detect u_hit_detect (
    .base_x_i  (base_x_q),
    .base_y_i  (base_y_q),
    .shot_x_i  (shot_x),
    .shot_y_i  (shot_y),
    .alive_i   (alive_q),
    .hit_any_o (hit_any),
    .hit_idx_o (hit_idx),
    .lc_o      (lc),
    .rc_o      (rc),
    .lr_o      (lr)
  );

  // Edges and invasion depth come from the pre-hit mask held in alive_q.
  assign edge_l    = base_x_q + CRD_W'(lc) * CRD_W'(DX);
  assign edge_r    = base_x_q + CRD_W'(rc) * CRD_W'(DX) + CRD_W'(ENEMY_W);
  assign descent_y = base_y_q + CRD_W'(STEP_Y);
  assign bottom    = descent_y + CRD_W'(lr) * CRD_W'(DY) + CRD_W'(ENEMY_H);

  assign tick     = run && (state_q != StHalt) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign shot_hit = shot_valid && armed_q && hit_any;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    alive_d    = alive_q;
    count_d    = count_q;
    hit_d      = 1'b0;
    hit_id_d   = hit_id_q;
    reached_d  = reached_q;
    armed_d    = armed_q;
    descend    = 1'b0;

    if (run && (state_q != StHalt)) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    if (tick) begin
      case (state_q)
        StMarchR: begin
          if (edge_r + CRD_W'(STEP_X) > CRD_W'(X_MAX)) descend = 1'b1;
          else base_x_d = base_x_q + CRD_W'(STEP_X);
        end
        StMarchL: begin
          if (edge_l < CRD_W'(X_MIN + STEP_X)) descend = 1'b1;
          else base_x_d = base_x_q - CRD_W'(STEP_X);
        end
        default: ;
      endcase
    end

    if (descend) begin
      base_y_d = descent_y;
      state_d  = (state_q == StMarchR) ? StMarchL : StMarchR;
      if (bottom >= CRD_W'(Y_LIMIT)) begin
        reached_d = 1'b1;
        state_d   = StHalt;
      end
    end

    if (!shot_valid) armed_d = 1'b1;
    else if (shot_hit) armed_d = 1'b0;

    if (shot_hit) begin
      hit_d            = 1'b1;
      hit_id_d         = hit_idx;
      alive_d[hit_idx] = 1'b0;
      count_d          = count_q - CNT_W'(1);
    end

    all_dead_d = (alive_d == '0);
    if (all_dead_d) state_d = StHalt;

    if (restart) begin
      state_d    = StMarchR;
      tick_cnt_d = '0;
      base_x_d   = CRD_W'(X0);
      base_y_d   = CRD_W'(Y0);
      alive_d    = '1;
      count_d    = CNT_W'(NUM_ENEMIES);
      hit_d      = 1'b0;
      hit_id_d   = '0;
      reached_d  = 1'b0;
      all_dead_d = 1'b0;
      armed_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StMarchR;
      tick_cnt_q <= '0;
      base_x_q   <= CRD_W'(X0);
      base_y_q   <= CRD_W'(Y0);
      alive_q    <= '1;
      count_q    <= CNT_W'(NUM_ENEMIES);
      hit_q      <= 1'b0;
      hit_id_q   <= '0;
      reached_q  <= 1'b0;
      all_dead_q <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      alive_q    <= alive_d;
      count_q    <= count_d;
      hit_q      <= hit_d;
      hit_id_q   <= hit_id_d;
      reached_q  <= reached_d;
      all_dead_q <= all_dead_d;
      armed_q    <= armed_d;
    end
  end

  assign base_x         = base_x_q[9:0];
  assign base_y         = base_y_q[9:0];
  assign alive          = alive_q;
  assign alive_count    = count_q;
  assign hit            = hit_q;
  assign hit_id         = hit_id_q;
  assign reached_bottom = reached_q;
  assign all_dead       = all_dead_q;

endmodule
